ib_ram_update_loader: RTL and testbench
=======================================

# ib_ram_update_loader

Single-clock controller that streams one iteration's worth of IB-CNU lookup-table content into the symmetric CN LUT RAM ahead of each decoding iteration. It accepts LUT words over a valid/ready stream and drives the RAM write port of the `cnu6_f0` stage: `page_addr_ram`, `ram_write_data_0` and `ib_ram_we`. It writes every page of the target multi-frame half, then reports completion. It sits directly upstream of the CNU6 F0 datapath, on its write side.

## Interface
Parameters:
- `LUT_PORT_SIZE`, 2: bits per bank per LUT word.
- `BANK_NUM`, 2: banks written per beat.
- `ENTRY_ADDR`, 4: page-address width; the MSB is the multi-frame write offset.
- `MULTI_FRAME_NUM`, 2: number of frames; the offset width is `$clog2(MULTI_FRAME_NUM)`.
- `ITER_MAX`, 50: iteration counter wraps after `ITER_MAX-1`.

Ports:
- `write_clk`, in, 1: sole clock.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `load_start`, in, 1: one-cycle start request.
- `load_frame`, in, 1: target frame offset, sampled with `load_start`.
- `din`, in, `LUT_PORT_SIZE*BANK_NUM`: LUT word. The upper `LUT_PORT_SIZE` bits are bank0.
- `din_valid`, in, 1: `din` is valid.
- `din_ready`, out, 1: loader accepts `din`.
- `page_addr_ram`, out, `ENTRY_ADDR`: `{frame, page}` write address.
- `ram_write_data_0`, out, `LUT_PORT_SIZE*BANK_NUM`: write data.
- `ib_ram_we`, out, 1: RAM write enable.
- `busy`, out, 1: a load is in progress.
- `load_done`, out, 1: one-cycle pulse when the last page has been written.
- `iter_cnt`, out, `$clog2(ITER_MAX)`: number of completed loads, modulo `ITER_MAX`.
- `load_checksum`, out, `LUT_PORT_SIZE*BANK_NUM`: checksum of the last completed load (see Configuration).

## Operation
- Page count per frame: `PAGE_NUM = 2**(ENTRY_ADDR-$clog2(MULTI_FRAME_NUM))`, which is 8 with the defaults.
- FSM states are IDLE, LOAD and DONE.
- IDLE:
  - `din_ready=0`, `busy=0`.
  - On `load_start=1`, latch `load_frame`, clear the page counter and go to LOAD.
- LOAD:
  - `busy=1`, `din_ready=1`.
  - A beat is accepted when `din_valid & din_ready`.
  - On each accepted beat, register `ram_write_data_0<=din`, `page_addr_ram<={frame,page}` and `ib_ram_we<=1`, then increment `page`.
  - If no beat is accepted in a cycle, `ib_ram_we<=0` and the address and data outputs hold their values.
  - On the beat where `page==PAGE_NUM-1`, drop `din_ready` combinationally in the following cycle and go to DONE.
- DONE:
  - `busy=1`, `din_ready=0`.
  - Assert `load_done=1` for exactly one cycle.
  - Update `iter_cnt`: `ITER_MAX-1` wraps to 0, otherwise increment.
  - Return to IDLE.
- `load_start` is ignored while `busy=1`. `load_start` in the same cycle as DONE is ignored; it is accepted in IDLE the next cycle at the earliest.
- Data presented with `din_valid` while in IDLE is not consumed and not written.
- Page wrap: the counter never exceeds `PAGE_NUM-1`. Excess beats stay unconsumed because `din_ready=0`.

## Timing
- Reset values: state IDLE; every output 0, including `page_addr_ram`, `ram_write_data_0`, `ib_ram_we`, `busy`, `load_done`, `iter_cnt` and `load_checksum`.
- Reset asserted mid-load clears everything immediately. The partial load does not pulse `load_done` and does not advance `iter_cnt`.
- Write latency: an accepted beat appears on the RAM port one cycle later, with `ib_ram_we=1` for exactly that cycle.
- A full load with back-to-back valid beats takes 1 start cycle, `PAGE_NUM` beat cycles and 1 DONE cycle. `load_done` is high in the cycle after the last `ib_ram_we` pulse.
- `din_ready` is a registered function of state only; it does not depend on `din_valid`.

## Configuration
- `IB_RAM_LOAD_CHECKSUM_EN` defined: a running XOR of every accepted `din` is kept. It clears on load start and is copied to `load_checksum` in the DONE cycle.
- Not defined: the accumulator logic is absent and `load_checksum` is tied to 0.

## Structure
- Shared package holds:
  - the FSM state encoding type (IDLE/LOAD/DONE);
  - the `PAGE_NUM` derivation;
  - the LUT word width constant `LUT_PORT_SIZE*BANK_NUM`.
- One sub-module, `ib_iter_counter`: the modulo-`ITER_MAX` counter with an increment-enable input, which the decoder controller can reuse.

## Test plan
- Reset, then `load_start` with `load_frame=1` and 8 back-to-back beats `0x0..0x7` -> `ib_ram_we` high for 8 consecutive cycles with `page_addr_ram` `0x8..0xF` and data `0x0..0x7`; `load_done` pulses once; `iter_cnt=1`.
- `load_frame=0` with `din_valid` toggling every other cycle -> 8 writes at addresses `0x0..0x7`; `we` gaps match the valid gaps; no duplicated addresses.
- `load_start` pulsed during LOAD, plus 9 valid beats offered -> the second start is ignored; exactly 8 writes; the 9th beat stays unconsumed with `din_ready=0`.
- `rstn` asserted after 3 writes -> all outputs 0 immediately; no `load_done`; `iter_cnt` stays 0; a subsequent load starts again at page 0.
- `ITER_MAX=3`, 4 complete loads -> `iter_cnt` sequence 1, 2, 0, 1.
- With `IB_RAM_LOAD_CHECKSUM_EN` and data `0x1,0x2,0x4,0x8,0x1,0x2,0x4,0x8` -> `load_checksum=0x0`. With data all `0x5` except the last beat `0xA` -> `load_checksum=0xF`. Without the macro -> `load_checksum=0` in both cases.

Source files
------------

// File: rtl/ib_ram_update_loader_pkg.sv
// Shared definitions for the IB-CNU LUT RAM update loader.
//   ib_state_t     : loader FSM state encoding (IDLE / LOAD / DONE)
//   ib_page_num()  : pages per multi-frame half, 2**(ENTRY_ADDR - clog2(MULTI_FRAME_NUM))
//   ib_lut_word_w(): LUT word width, LUT_PORT_SIZE * BANK_NUM
package ib_ram_update_loader_pkg;

  typedef logic [1:0] ib_state_t;

  localparam ib_state_t ST_IDLE = 2'd0;
  localparam ib_state_t ST_LOAD = 2'd1;
  localparam ib_state_t ST_DONE = 2'd2;

  localparam int unsigned LUT_W_DEFAULT = 4;

  function automatic int unsigned ib_page_num(input int unsigned entry_addr,
                                              input int unsigned multi_frame_num);
    return 32'd1 << (entry_addr - unsigned'($clog2(multi_frame_num)));
  endfunction

  function automatic int unsigned ib_lut_word_w(input int unsigned lut_port_size,
                                                input int unsigned bank_num);
    return lut_port_size * bank_num;
  endfunction

endpackage

// File: rtl/ib_ram_update_loader_if.sv
// LUT word stream (valid/ready) feeding the IB RAM update loader.
//   din       : LUT word, upper LUT_PORT_SIZE bits are bank0
//   din_valid : din is valid
//   din_ready : loader accepts din
// Modports: master (LUT source), slave (loader).
interface ib_ram_update_loader_if
  import ib_ram_update_loader_pkg::*;
#(
  parameter int unsigned W = LUT_W_DEFAULT
) ();
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/ib_ram_update_loader_iter_counter.sv
// ib_iter_counter: modulo-ITER_MAX counter with increment enable.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc_en     : advance the count this cycle
//   cnt        : current count, ITER_MAX-1 wraps to 0
module ib_iter_counter #(
  parameter  int unsigned ITER_MAX = 50,
  localparam int unsigned CW       = unsigned'($clog2(ITER_MAX))
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_en,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc_en) begin
      cnt <= (cnt == CW'(ITER_MAX - 1)) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ib_ram_update_loader.sv
// ib_ram_update_loader: streams one iteration of IB-CNU LUT words into the
// cnu6_f0 symmetric CN LUT RAM write port, one page per accepted beat, over
// every page of the selected multi-frame half, then pulses load_done.
// Ports:
//   write_clk, rstn   : clock, asynchronous active-low reset
//   load_start        : one-cycle start request (honoured in IDLE only)
//   load_frame        : target frame offset, sampled with load_start
//   lut_in            : LUT word stream (slave modport)
//   page_addr_ram     : {frame, page} write address
//   ram_write_data_0  : write data
//   ib_ram_we         : RAM write enable, one cycle per accepted beat
//   busy              : load in progress (LOAD or DONE)
//   load_done         : one-cycle pulse after the last page is written
//   iter_cnt          : completed loads modulo ITER_MAX
//   load_checksum     : XOR of the last completed load's words
// Build option: IB_RAM_LOAD_CHECKSUM_EN enables the checksum accumulator;
// otherwise load_checksum is tied to 0.
module ib_ram_update_loader
  import ib_ram_update_loader_pkg::*;
#(
  parameter  int unsigned LUT_PORT_SIZE   = 2,
  parameter  int unsigned BANK_NUM        = 2,
  parameter  int unsigned ENTRY_ADDR      = 4,
  parameter  int unsigned MULTI_FRAME_NUM = 2,
  parameter  int unsigned ITER_MAX        = 50,
  localparam int unsigned LUT_W           = ib_lut_word_w(LUT_PORT_SIZE, BANK_NUM),
  localparam int unsigned ITER_W          = unsigned'($clog2(ITER_MAX))
) (
  input  logic                     write_clk,
  input  logic                     rstn,
  input  logic                     load_start,
  input  logic                     load_frame,
  ib_ram_update_loader_if.slave    lut_in,
  output logic [ENTRY_ADDR-1:0]    page_addr_ram,
  output logic [LUT_W-1:0]         ram_write_data_0,
  output logic                     ib_ram_we,
  output logic                     busy,
  output logic                     load_done,
  output logic [ITER_W-1:0]        iter_cnt,
  output logic [LUT_W-1:0]         load_checksum
);

  localparam int unsigned FRAME_W  = unsigned'($clog2(MULTI_FRAME_NUM));
  localparam int unsigned PAGE_W   = ENTRY_ADDR - FRAME_W;
  localparam int unsigned PAGE_NUM = ib_page_num(ENTRY_ADDR, MULTI_FRAME_NUM);
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGE_NUM - 1);

  ib_state_t          state;
  logic [FRAME_W-1:0] frame_q;
  logic [PAGE_W-1:0]  page_q;
  logic               start_acc;
  logic               beat;
  logic               done_cyc;

  // Ready is decoded from the state register alone, so it never depends on din_valid.
  assign lut_in.din_ready = (state == ST_LOAD);
  assign busy             = (state != ST_IDLE);
  assign start_acc        = (state == ST_IDLE) && load_start;
  assign beat             = (state == ST_LOAD) && lut_in.din_valid;
  assign done_cyc         = (state == ST_DONE);

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state            <= ST_IDLE;
      frame_q          <= '0;
      page_q           <= '0;
      page_addr_ram    <= '0;
      ram_write_data_0 <= '0;
      ib_ram_we        <= 1'b0;
      load_done        <= 1'b0;
    end else begin
      ib_ram_we <= 1'b0;
      load_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_start) begin
            frame_q <= FRAME_W'(load_frame);
            page_q  <= '0;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (lut_in.din_valid) begin
            ram_write_data_0 <= lut_in.din;
            page_addr_ram    <= {frame_q, page_q};
            ib_ram_we        <= 1'b1;
            // Wraps to 0 on the last page, so the counter never exceeds PAGE_NUM-1.
            page_q           <= page_q + PAGE_W'(1);
            if (page_q == PAGE_LAST) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Registered so the pulse lands in the cycle after the last write-enable.
          load_done <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef IB_RAM_LOAD_CHECKSUM_EN
  logic [LUT_W-1:0] csum_acc;

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      csum_acc      <= '0;
      load_checksum <= '0;
    end else if (start_acc) begin
      csum_acc <= '0;
    end else if (beat) begin
      csum_acc <= csum_acc ^ lut_in.din;
    end else if (done_cyc) begin
      load_checksum <= csum_acc;
    end
  end
`else
  assign load_checksum = '0;
`endif

  ib_iter_counter #(
    .ITER_MAX (ITER_MAX)
  ) u_iter_counter (
    .clk    (write_clk),
    .rst_n  (rstn),
    .inc_en (done_cyc),
    .cnt    (iter_cnt)
  );

endmodule

// File: tb/tb_ib_ram_update_loader.sv
module tb_ib_ram_update_loader;

  logic       write_clk = 1'b0;
  logic       rstn;
  logic       load_start;
  logic       load_frame;
  logic [3:0] din;
  logic       din_valid;

  logic [3:0] page_addr_ram,  page_addr_ram2;
  logic [3:0] ram_write_data_0, ram_write_data_2;
  logic       ib_ram_we, ib_ram_we2;
  logic       busy, busy2;
  logic       load_done, load_done2;
  logic [5:0] iter_cnt;
  logic [1:0] iter_cnt2;
  logic [3:0] load_checksum, load_checksum2;

  always #5 write_clk = ~write_clk;

  ib_ram_update_loader_if #(.W(4)) lut_if  ();
  ib_ram_update_loader_if #(.W(4)) lut_if2 ();

  assign lut_if.din        = din;
  assign lut_if.din_valid  = din_valid;
  assign lut_if2.din       = din;
  assign lut_if2.din_valid = din_valid;

  ib_ram_update_loader dut (
    .write_clk        (write_clk),
    .rstn             (rstn),
    .load_start       (load_start),
    .load_frame       (load_frame),
    .lut_in           (lut_if.slave),
    .page_addr_ram    (page_addr_ram),
    .ram_write_data_0 (ram_write_data_0),
    .ib_ram_we        (ib_ram_we),
    .busy             (busy),
    .load_done        (load_done),
    .iter_cnt         (iter_cnt),
    .load_checksum    (load_checksum)
  );

  ib_ram_update_loader #(.ITER_MAX(3)) dut3 (
    .write_clk        (write_clk),
    .rstn             (rstn),
    .load_start       (load_start),
    .load_frame       (load_frame),
    .lut_in           (lut_if2.slave),
    .page_addr_ram    (page_addr_ram2),
    .ram_write_data_0 (ram_write_data_2),
    .ib_ram_we        (ib_ram_we2),
    .busy             (busy2),
    .load_done        (load_done2),
    .iter_cnt         (iter_cnt2),
    .load_checksum    (load_checksum2)
  );

  typedef struct { logic [3:0] addr; logic [3:0] data; } wr_t;
  typedef struct { int iter; logic [3:0] cs; } done_t;

  wr_t   wr_q[$];
  done_t done_q[$];
  int    done3_q[$];

  int errors = 0;
  int checks = 0;
  int loads  = 0;
  logic [3:0] stim[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT presents a write or a done pulse.
  always @(negedge write_clk) begin
    if (rstn === 1'b1) begin
      if (ib_ram_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write_addr", {28'd0, page_addr_ram}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          check("write_addr", {28'd0, page_addr_ram}, {28'd0, e.addr});
          check("write_data", {28'd0, ram_write_data_0}, {28'd0, e.data});
        end
      end
      if (load_done) begin
        if (done_q.size() == 0) begin
          check("unexpected_load_done", 32'd1, 32'd0);
        end else begin
          done_t d;
          d = done_q.pop_front();
          check("iter_cnt", {26'd0, iter_cnt}, d.iter);
          check("load_checksum", {28'd0, load_checksum}, {28'd0, d.cs});
          check("busy_after_done", {31'd0, busy}, 32'd0);
        end
      end
      if (load_done2) begin
        if (done3_q.size() == 0) begin
          check("unexpected_load_done_itermax3", 32'd1, 32'd0);
        end else begin
          check("iter_cnt_itermax3", {30'd0, iter_cnt2}, done3_q.pop_front());
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_din_ready"}, {31'd0, lut_if.din_ready}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_we"}, {31'd0, ib_ram_we}, 32'd0);
    check({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
    check({tag, "_addr"}, {28'd0, page_addr_ram}, 32'd0);
    check({tag, "_data"}, {28'd0, ram_write_data_0}, 32'd0);
    check({tag, "_iter_cnt"}, {26'd0, iter_cnt}, 32'd0);
    check({tag, "_iter_cnt3"}, {30'd0, iter_cnt2}, 32'd0);
    check({tag, "_checksum"}, {28'd0, load_checksum}, 32'd0);
  endtask

  // mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps.
  // abort_after > 0: assert reset once that many beats have been accepted.
  task automatic run_load(input logic frame, input int mode, input int abort_after,
                          input bit extra);
    int idx = 0;
    int cyc = 0;
    int nw;
    logic [3:0] cs = 4'h0;
    bit acc;
    nw = (abort_after > 0) ? abort_after : 8;
    for (int i = 0; i < nw; i++) wr_q.push_back('{addr: {frame, 3'(i)}, data: stim[i]});
    if (abort_after == 0) begin
      for (int i = 0; i < 8; i++) cs ^= stim[i];
`ifndef IB_RAM_LOAD_CHECKSUM_EN
      cs = 4'h0;
`endif
      loads++;
      done_q.push_back('{iter: loads % 50, cs: cs});
      done3_q.push_back(loads % 3);
    end

    @(posedge write_clk); #1;
    load_start = 1'b1; load_frame = frame; din_valid = 1'b0;
    @(posedge write_clk); #1;
    load_start = 1'b0;
    while (idx < 8 && cyc < 200) begin
      case (mode)
        0:       din_valid = 1'b1;
        1:       din_valid = (cyc % 2 == 0);
        default: din_valid = ($urandom_range(0, 99) < 60);
      endcase
      din = din_valid ? stim[idx] : 4'($urandom);
      load_start = extra && (idx == 3);
      load_frame = ~frame;
      @(negedge write_clk);
      acc = lut_if.din_ready && din_valid;
      @(posedge write_clk); #1;
      load_start = 1'b0;
      if (acc) idx++;
      cyc++;
      if (abort_after > 0 && idx == abort_after) break;
    end
    din_valid = 1'b0;

    if (abort_after > 0) begin
      @(negedge write_clk); #1;
      rstn = 1'b0;
      #1;
      check_all_zero("reset_mid_load");
      loads = 0;
      @(posedge write_clk); #1;
      rstn = 1'b1;
    end else begin
      check("load_completed_within_budget", idx, 8);
      if (extra) begin
        din_valid = 1'b1; din = 4'hC;
        for (int k = 0; k < 4; k++) begin
          @(negedge write_clk);
          check("extra_beat_not_ready", {31'd0, lut_if.din_ready}, 32'd0);
        end
        din_valid = 1'b0;
      end
    end
    repeat (3) @(posedge write_clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; load_start = 1'b0; load_frame = 1'b0; din = 4'h0; din_valid = 1'b0;
    repeat (3) @(posedge write_clk);
    #1 rstn = 1'b1;
    @(negedge write_clk);
    check_all_zero("reset");

    // Valid data offered in IDLE must not be written.
    din_valid = 1'b1; din = 4'h9;
    repeat (3) @(negedge write_clk);
    check("idle_not_ready", {31'd0, lut_if.din_ready}, 32'd0);
    din_valid = 1'b0;

    for (int i = 0; i < 8; i++) stim[i] = 4'($urandom);
    run_load(1'b0, 0, 3, 1'b0);

    for (int i = 0; i < 8; i++) stim[i] = 4'(i);
    run_load(1'b1, 0, 0, 1'b0);

    for (int i = 0; i < 8; i++) stim[i] = 4'($urandom);
    run_load(1'b0, 1, 0, 1'b0);

    for (int i = 0; i < 8; i++) stim[i] = 4'($urandom);
    run_load(1'($urandom), 0, 0, 1'b1);

    for (int i = 0; i < 8; i++) stim[i] = 4'(1 << (i % 4));
    run_load(1'b0, 0, 0, 1'b0);

    for (int i = 0; i < 8; i++) stim[i] = (i == 7) ? 4'hA : 4'h5;
    run_load(1'b1, 1, 0, 1'b0);

    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 8; i++) stim[i] = 4'($urandom);
      run_load(1'($urandom), 2, 0, 1'b0);
    end

    repeat (4) @(negedge write_clk);
    check("pending_writes", wr_q.size(), 0);
    check("pending_done", done_q.size(), 0);
    check("pending_done_itermax3", done3_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
